// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: once-per-frame Pong controller (pclk, rst_n; vblnk_in/start/buttons in; palette, ball, score and state out)
module pong_game_ctrl #(
  parameter int SCREEN_W     = 1024,
  parameter int SCREEN_H     = 768,
  parameter int PAD_HALF     = 100,
  parameter int PAD_W        = 10,
  parameter int BALL_HALF    = 3,
  parameter int BALL_SPEED   = 2,
  parameter int PAD_SPEED    = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic        left_up,
  input  logic        left_down,
  input  logic        right_up,
  input  logic        right_down,
  output logic [10:0] left_palette_pos,
  output logic [10:0] right_palette_pos,
  output logic [10:0] ball_xpos,
  output logic [10:0] ball_ypos,
  output logic [3:0]  left_score,
  output logic [3:0]  right_score,
  output logic [1:0]  game_state,
  output logic        game_over
);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SF = CW'(SERVE_FRAMES);
  localparam logic [3:0] WS = 4'(WIN_SCORE);
  localparam logic [10:0] CX = 11'(SCREEN_W / 2);
  localparam logic [10:0] CY = 11'(SCREEN_H / 2);
  localparam logic [11:0] PH = 12'(PAD_HALF);
  localparam logic [11:0] PS = 12'(PAD_SPEED);
  localparam logic [11:0] BH = 12'(BALL_HALF);
  localparam logic [11:0] BS = 12'(BALL_SPEED);
  localparam logic [11:0] P_MAX = 12'(SCREEN_H - 1 - PAD_HALF);
  localparam logic [11:0] Y_BOT = 12'(SCREEN_H - 1 - BALL_HALF);
  localparam logic [11:0] X_L = 12'(PAD_W + BALL_HALF);
  localparam logic [11:0] X_R = 12'(SCREEN_W - PAD_W - BALL_HALF);
  // Wall/edge tests folded onto the current coordinate so nothing underflows
  localparam logic [11:0] Y_BLIM = 12'(SCREEN_H - 1 - BALL_HALF - BALL_SPEED);
  localparam logic [11:0] Y_TLIM = 12'(BALL_HALF + BALL_SPEED);
  localparam logic [11:0] X_LLIM = 12'(PAD_W + BALL_HALF + BALL_SPEED);
  localparam logic [11:0] X_RLIM = 12'(SCREEN_W - PAD_W - BALL_HALF - BALL_SPEED);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  state_t state, state_nx;
  logic vblnk_d, tick, dir_x, dir_y, dir_x_nx, dir_y_nx, l_edge, r_edge, l_hit, r_hit;
  logic [CW-1:0] serve_cnt, cnt_nx;
  logic [10:0] lp_nx, rp_nx, bx_nx, by_nx;
  logic [3:0] ls_nx, rs_nx;
  logic [11:0] x, y, lp, rp;
  function automatic logic [10:0] pad_step(input logic [10:0] pos, input logic up, input logic dn);
    logic [11:0] p;
    p = {1'b0, pos};
    return 11'((up && !dn) ? ((p < PH + PS) ? PH : p - PS) :
               (dn && !up) ? ((p > P_MAX - PS) ? P_MAX : p + PS) : p);
  endfunction
  assign tick = vblnk_in & ~vblnk_d;
  assign game_state = state;
  assign game_over = state == OVER;
  always_comb begin
    x = {1'b0, ball_xpos};
    y = {1'b0, ball_ypos};
    lp = {1'b0, left_palette_pos};
    rp = {1'b0, right_palette_pos};
    l_edge = !dir_x && x < X_LLIM;
    r_edge = dir_x && x > X_RLIM;
    // Overlap test uses the palette position from before this frame's move
    l_hit = y + BH + PH > lp && y < lp + PH + BH;
    r_hit = y + BH + PH > rp && y < rp + PH + BH;
    lp_nx = state == OVER ? left_palette_pos : pad_step(left_palette_pos, left_up, left_down);
    rp_nx = state == OVER ? right_palette_pos : pad_step(right_palette_pos, right_up, right_down);
    state_nx = state;
    cnt_nx = serve_cnt;
    bx_nx = ball_xpos;
    by_nx = ball_ypos;
    dir_x_nx = dir_x;
    dir_y_nx = dir_y;
    ls_nx = left_score;
    rs_nx = right_score;
    case (state)
      IDLE: if (start) begin
        state_nx = SERVE;
        cnt_nx = SF;
      end
      SERVE: begin
        state_nx = serve_cnt == '0 ? PLAY : SERVE;
        cnt_nx = serve_cnt == '0 ? serve_cnt : serve_cnt - CW'(1);
      end
      PLAY: begin
        by_nx = 11'(dir_y ? (y >= Y_BLIM ? Y_BOT : y + BS) : (y <= Y_TLIM ? BH : y - BS));
        dir_y_nx = dir_y ? y < Y_BLIM : y <= Y_TLIM;
        bx_nx = 11'(l_edge ? X_L : r_edge ? X_R : dir_x ? x + BS : x - BS);
        dir_x_nx = l_edge | (dir_x & ~r_edge);
        if ((l_edge && !l_hit) || (r_edge && !r_hit)) begin
          ls_nx = left_score + 4'(r_edge);
          rs_nx = right_score + 4'(l_edge);
          bx_nx = CX;
          by_nx = CY;
          dir_x_nx = r_edge;
          dir_y_nx = 1'b1;
          state_nx = (ls_nx == WS || rs_nx == WS) ? OVER : SERVE;
          cnt_nx = SF;
        end
      end
      default: if (start) begin
        ls_nx = '0;
        rs_nx = '0;
        bx_nx = CX;
        by_nx = CY;
        state_nx = SERVE;
        cnt_nx = SF;
      end
    endcase
  end
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      vblnk_d <= 1'b0;
      state <= IDLE;
      serve_cnt <= '0;
      left_palette_pos <= CY;
      right_palette_pos <= CY;
      ball_xpos <= CX;
      ball_ypos <= CY;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      left_score <= '0;
      right_score <= '0;
    end else begin
      vblnk_d <= vblnk_in;
      if (tick) begin
        state <= state_nx;
        serve_cnt <= cnt_nx;
        left_palette_pos <= lp_nx;
        right_palette_pos <= rp_nx;
        ball_xpos <= bx_nx;
        ball_ypos <= by_nx;
        dir_x <= dir_x_nx;
        dir_y <= dir_y_nx;
        left_score <= ls_nx;
        right_score <= rs_nx;
      end
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: vector table, directed game sequences and random frames against a frame-level game model
module tb_pong_game_ctrl;
  logic pclk = 1'b0, rst_n = 1'b0, vblnk_in = 1'b0, start = 1'b0;
  logic left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
  logic [10:0] left_palette_pos, right_palette_pos, ball_xpos, ball_ypos;
  logic [3:0] left_score, right_score;
  logic [1:0] game_state;
  logic game_over;
  int n_pass = 0, n_total = 0;
  int m_lp, m_rp, m_bx, m_by, m_ls, m_rs, m_st, m_cnt, m_dx, m_dy;
  typedef struct { bit s, lu, ld, ru, rd; int lp, rp, st; } vec_t;
  vec_t vecs[11];

  pong_game_ctrl dut (
    .pclk(pclk), .rst_n(rst_n), .vblnk_in(vblnk_in), .start(start),
    .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
    .left_palette_pos(left_palette_pos), .right_palette_pos(right_palette_pos),
    .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
    .left_score(left_score), .right_score(right_score),
    .game_state(game_state), .game_over(game_over)
  );

  always #5ns pclk = ~pclk;

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic m_reset();
    m_lp = 384; m_rp = 384; m_bx = 512; m_by = 384;
    m_ls = 0; m_rs = 0; m_st = 0; m_cnt = 0; m_dx = 1; m_dy = 1;
  endtask

  function automatic int pad(input int p, input bit u, input bit d);
    if (u && !d) return (p - 4 < 100) ? 100 : p - 4;
    if (d && !u) return (p + 4 > 667) ? 667 : p + 4;
    return p;
  endfunction

  function automatic bit hit(input int y, input int p);
    return (y + 3 > p - 100) && (y - 3 < p + 100);
  endfunction

  task automatic miss(input bit right_side);
    int sc;
    if (right_side) begin m_ls++; sc = m_ls; m_dx = 1; end
    else begin m_rs++; sc = m_rs; m_dx = -1; end
    m_bx = 512; m_by = 384; m_dy = 1; m_cnt = 60;
    m_st = (sc == 9) ? 3 : 1;
  endtask

  task automatic model_tick(input bit s, input bit lu, input bit ld, input bit ru, input bit rd);
    int nlp, nrp, oy, nx, ny;
    nlp = (m_st == 3) ? m_lp : pad(m_lp, lu, ld);
    nrp = (m_st == 3) ? m_rp : pad(m_rp, ru, rd);
    case (m_st)
      0: if (s) begin m_st = 1; m_cnt = 60; end
      1: if (m_cnt == 0) m_st = 2; else m_cnt--;
      2: begin
        oy = m_by; nx = m_bx + 2 * m_dx; ny = m_by + 2 * m_dy;
        if (m_dy > 0 && ny + 3 >= 767) begin m_by = 764; m_dy = -1; end
        else if (m_dy < 0 && ny - 3 <= 0) begin m_by = 3; m_dy = 1; end
        else m_by = ny;
        if (m_dx < 0 && nx - 3 < 10) begin
          if (hit(oy, m_lp)) begin m_bx = 13; m_dx = 1; end else miss(1'b0);
        end else if (m_dx > 0 && nx + 3 > 1014) begin
          if (hit(oy, m_rp)) begin m_bx = 1011; m_dx = -1; end else miss(1'b1);
        end else m_bx = nx;
      end
      default: if (s) begin m_ls = 0; m_rs = 0; m_bx = 512; m_by = 384; m_st = 1; m_cnt = 60; end
    endcase
    m_lp = nlp; m_rp = nrp;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".lp"}, left_palette_pos, m_lp);
    chk({tag, ".rp"}, right_palette_pos, m_rp);
    chk({tag, ".bx"}, ball_xpos, m_bx);
    chk({tag, ".by"}, ball_ypos, m_by);
    chk({tag, ".ls"}, left_score, m_ls);
    chk({tag, ".rs"}, right_score, m_rs);
    chk({tag, ".st"}, game_state, m_st);
    chk({tag, ".go"}, game_over, int'(m_st == 3));
  endtask

  // One frame: inputs valid at the vblnk rising edge, junk on them for the rest of the frame
  task automatic frame(input string tag, input bit s, input bit lu, input bit ld, input bit ru, input bit rd);
    @(negedge pclk);
    {start, left_up, left_down, right_up, right_down} = {s, lu, ld, ru, rd};
    vblnk_in = 1'b1;
    @(negedge pclk);
    model_tick(s, lu, ld, ru, rd);
    {start, left_up, left_down, right_up, right_down} = 5'($urandom);
    @(negedge pclk);
    vblnk_in = 1'b0;
    @(negedge pclk);
    check_all(tag);
  endtask

  initial begin
    int fbx, fby, flp, frp;
    vecs = '{
      '{0,0,0,0,0, 384,384,0}, '{0,0,0,0,0, 384,384,0}, '{0,0,0,0,0, 384,384,0},
      '{0,0,0,0,0, 384,384,0}, '{0,0,0,0,0, 384,384,0},
      '{0,1,0,0,0, 380,384,0}, '{0,1,1,0,0, 380,384,0}, '{0,0,0,0,1, 380,388,0},
      '{0,0,0,1,1, 380,388,0}, '{0,0,1,1,0, 384,384,0}, '{0,0,1,0,0, 388,384,0}
    };
    m_reset();
    repeat (3) @(negedge pclk);
    chk("rst.lp", left_palette_pos, 384);
    chk("rst.rp", right_palette_pos, 384);
    chk("rst.bx", ball_xpos, 512);
    chk("rst.by", ball_ypos, 384);
    chk("rst.st", game_state, 0);
    chk("rst.go", game_over, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      frame("vec", vecs[i].s, vecs[i].lu, vecs[i].ld, vecs[i].ru, vecs[i].rd);
      chk("vec.lp", left_palette_pos, vecs[i].lp);
      chk("vec.rp", right_palette_pos, vecs[i].rp);
      chk("vec.st", game_state, vecs[i].st);
      chk("vec.bx", ball_xpos, 512);
    end
    for (int i = 0; i < 80; i++) frame("clamp", 0, 1, 0, 0, 1);
    chk("clamp.lp", left_palette_pos, 100);
    chk("clamp.rp", right_palette_pos, 667);
    for (int i = 0; i < 3; i++) frame("hold", 0, 1, 0, 1, 1);
    chk("hold.lp", left_palette_pos, 100);
    chk("hold.rp", right_palette_pos, 667);
    frame("serve", 1, 0, 0, 0, 0);
    chk("serve.st", game_state, 1);
    for (int i = 0; i < 60; i++) frame("serve", 0, 0, 0, 0, 0);
    chk("serve60.st", game_state, 1);
    frame("serve", 0, 0, 0, 0, 0);
    chk("serve61.st", game_state, 2);
    chk("serve61.bx", ball_xpos, 512);
    frame("move", 0, 0, 0, 0, 0);
    chk("move.bx", ball_xpos, 514);
    chk("move.by", ball_ypos, 386);
    for (int k = 0; k < 600 && m_bx != 1011; k++)
      frame("track", 0, 1'($urandom), 1'($urandom), m_rp > m_by, m_rp < m_by);
    chk("hit.bx", ball_xpos, 1011);
    chk("hit.ls", left_score, 0);
    chk("hit.rs", right_score, 0);
    frame("rebound", 0, 0, 0, 0, 0);
    chk("rebound.bx", ball_xpos, 1009);
    for (int k = 0; k < 4000 && m_ls == 0; k++)
      frame("miss", 1'($urandom), m_lp > m_by, m_lp < m_by, 1, 0);
    chk("miss.ls", left_score, 1);
    chk("miss.st", game_state, 1);
    chk("miss.bx", ball_xpos, 512);
    chk("miss.by", ball_ypos, 384);
    for (int i = 0; i < 62; i++) frame("reserve", 0, 0, 0, 1, 0);
    chk("reserve.bx", ball_xpos, 514);
    for (int k = 0; k < 6000 && m_st != 3; k++)
      frame("toover", 0, m_lp > m_by, m_lp < m_by, 1, 0);
    chk("over.ls", left_score, 9);
    chk("over.st", game_state, 3);
    chk("over.go", game_over, 1);
    fbx = m_bx; fby = m_by; flp = m_lp; frp = m_rp;
    for (int i = 0; i < 10; i++) frame("frozen", 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("frozen.bx", ball_xpos, fbx);
    chk("frozen.by", ball_ypos, fby);
    chk("frozen.lp", left_palette_pos, flp);
    chk("frozen.rp", right_palette_pos, frp);
    frame("restart", 1, 0, 0, 0, 0);
    chk("restart.ls", left_score, 0);
    chk("restart.st", game_state, 1);
    chk("restart.go", game_over, 0);
    for (int i = 0; i < 70; i++) frame("replay", 0, 0, 1, 1, 0);
    chk("replay.st", game_state, 2);
    @(negedge pclk);
    #2ns rst_n = 1'b0;
    #1ns;
    chk("arst.lp", left_palette_pos, 384);
    chk("arst.rp", right_palette_pos, 384);
    chk("arst.bx", ball_xpos, 512);
    chk("arst.by", ball_ypos, 384);
    chk("arst.ls", left_score, 0);
    chk("arst.st", game_state, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    m_reset();
    frame("post", 1, 0, 0, 0, 0);
    chk("post.st", game_state, 1);
    for (int i = 0; i < 400; i++)
      frame("rand", $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
